// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: multiplier opcodes and the multiplier-share arbiter states.
package cpu_types_pkg;

   typedef enum logic [2:0] {
      MUL_NONE = 3'd0,
      MUL      = 3'd1,
      MULH     = 3'd2,
      MULHSU   = 3'd3,
      MULHU    = 3'd4
   } riscv_mul_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } mul_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, wrapping.
// Zero latency; any_grant is low when no bit of valid is set.
module rr_pick #(
   parameter int N = 2,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         any_grant
);

   logic [N-1:0] rotated;
   int           pos;

   // rotated[k] is valid[(ptr + k) mod N]
   assign rotated = N'({valid, valid} >> ptr);

   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      pos       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            pos       = int'(ptr) + k;
            any_grant = 1'b1;
         end
      end
      if (pos >= N) pos = pos - N;
      grant = W'(pos);
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one non-pipelined multiplier; one job in flight, result returned only to its owner.
// Grant->mul_in_valid 1 cycle, mul_out_valid->resp_valid 1 cycle; the result is held until the owner takes or flushes it.
module mul_share_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0][31:0] req_a,
   input  logic [NUM_REQ-1:0][31:0] req_b,
   input  riscv_mul_op_e            req_op [NUM_REQ],
   input  logic [NUM_REQ-1:0]       req_flush,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [31:0]              resp_data,
   output logic                     mul_in_valid,
   input  logic                     mul_in_ready,
   output logic [31:0]              mul_a,
   output logic [31:0]              mul_b,
   output riscv_mul_op_e            mul_op,
   input  logic                     mul_out_valid,
   output logic                     mul_out_ready,
   input  logic [31:0]              mul_out_data
);

   localparam int ID_W = $clog2(NUM_REQ);

   mul_arb_state_e     state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    owner;
   logic [ID_W-1:0]    grant;
   logic               any_grant;
   logic [NUM_REQ-1:0] eligible;
   logic               own_flush;
   logic               own_resp_ready;

   // A requester flushing this cycle is never granted
   assign eligible       = req_valid & ~req_flush;
   assign own_flush      = req_flush[owner];
   assign own_resp_ready = resp_ready[owner];

   rr_pick #(
      .N (NUM_REQ),
      .W (ID_W)
   ) u_pick (
      .valid     (eligible),
      .ptr       (rr_ptr),
      .grant     (grant),
      .any_grant (any_grant)
   );

   assign mul_in_valid  = (state == S_ISSUE);
   assign mul_out_ready = (state == S_WAIT) || (state == S_DRAIN);

   // req_ready is gated by rst so nothing is accepted while reset is held
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      if (rst && (state == S_IDLE) && any_grant) req_ready[grant] = 1'b1;
      if (state == S_RESP) resp_valid[owner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_op    <= MUL_NONE;
         resp_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_grant) begin
                  owner  <= grant;
                  mul_a  <= req_a[grant];
                  mul_b  <= req_b[grant];
                  mul_op <= req_op[grant];
                  rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Once the multiplier has taken the job its result must still be drained
               if (own_flush)         state <= mul_in_ready ? S_DRAIN : S_IDLE;
               else if (mul_in_ready) state <= S_WAIT;
            end
            S_WAIT: begin
               if (own_flush) begin
                  state <= mul_out_valid ? S_IDLE : S_DRAIN;
               end else if (mul_out_valid) begin
                  resp_data <= mul_out_data;
                  state     <= S_RESP;
               end
            end
            S_DRAIN: begin
               if (mul_out_valid) state <= S_IDLE;
            end
            S_RESP: begin
               if (own_flush || own_resp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
   assert property (@(posedge clk) disable iff (!rst) $onehot0(resp_valid));
   assert property (@(posedge clk) disable iff (!rst)
      (mul_in_valid && !mul_in_ready && !own_flush) |=>
      (mul_in_valid && $stable(mul_a) && $stable(mul_b) && $stable(mul_op)));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter; the bench plays the multiplier and both requesters.
module tb_mul_share_arbiter;
   import cpu_types_pkg::*;

   logic             clk;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   riscv_mul_op_e    req_op [2];
   logic [1:0]       req_flush;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [31:0]      resp_data;
   logic             mul_in_valid;
   logic             mul_in_ready;
   logic [31:0]      mul_a;
   logic [31:0]      mul_b;
   riscv_mul_op_e    mul_op;
   logic             mul_out_valid;
   logic             mul_out_ready;
   logic [31:0]      mul_out_data;

   int               checks;
   int               errors;
   logic [31:0]      cap_a;
   logic [31:0]      cap_b;
   riscv_mul_op_e    cap_op;

   mul_share_arbiter #(.NUM_REQ(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_op        (req_op),
      .req_flush     (req_flush),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .mul_in_valid  (mul_in_valid),
      .mul_in_ready  (mul_in_ready),
      .mul_a         (mul_a),
      .mul_b         (mul_b),
      .mul_op        (mul_op),
      .mul_out_valid (mul_out_valid),
      .mul_out_ready (mul_out_ready),
      .mul_out_data  (mul_out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Behaviour of the shared multiplier for whatever job it was handed
   function automatic logic [31:0] ref_mul(input riscv_mul_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] p;
      case (op)
         MULH:    p = $signed({{34{a[31]}}, a}) * $signed({{34{b[31]}}, b});
         MULHSU:  p = $signed({{34{a[31]}}, a}) * $signed({34'd0, b});
         default: p = $signed({34'd0, a}) * $signed({34'd0, b});
      endcase
      return (op == MUL) ? p[31:0] : p[63:32];
   endfunction

   task automatic accept(input string tag, input logic [31:0] ea, input logic [31:0] eb, input riscv_mul_op_e eop);
      int n = 0;
      while (!mul_in_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_in_valid"}, 32'(mul_in_valid), 32'd1);
      chk({tag, "_mul_a"}, mul_a, ea);
      chk({tag, "_mul_b"}, mul_b, eb);
      chk({tag, "_mul_op"}, 32'(mul_op), 32'(eop));
      cap_a        = mul_a;
      cap_b        = mul_b;
      cap_op       = mul_op;
      mul_in_ready = 1'b1;
      tick();
      mul_in_ready = 1'b0;
   endtask

   task automatic complete(input string tag, input int lat);
      repeat (lat) tick();
      chk({tag, "_out_ready"}, 32'(mul_out_ready), 32'd1);
      mul_out_valid = 1'b1;
      mul_out_data  = ref_mul(cap_op, cap_a, cap_b);
      tick();
      mul_out_valid = 1'b0;
      mul_out_data  = '0;
   endtask

   task automatic take_resp(input string tag, input int r, input logic [31:0] exp);
      logic [1:0] onehot;
      int n = 0;
      onehot = 2'b01 << r;
      while (resp_valid == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(onehot));
      chk({tag, "_resp_data"}, resp_data, exp);
      resp_ready[r] = 1'b1;
      tick();
      resp_ready = '0;
      chk({tag, "_resp_clear"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic single_job(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                             input riscv_mul_op_e op, input logic [31:0] exp);
      logic [1:0] onehot;
      onehot       = 2'b01 << r;
      req_a[r]     = a;
      req_b[r]     = b;
      req_op[r]    = op;
      req_valid[r] = 1'b1;
      #1;
      chk({tag, "_req_ready"}, 32'(req_ready), 32'(onehot));
      tick();
      req_valid[r] = 1'b0;
      accept(tag, a, b, op);
      complete(tag, 3);
      take_resp(tag, r, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clk           = 1'b0;
      rst           = 1'b0;
      checks        = 0;
      errors        = 0;
      req_valid     = 2'b11;
      req_flush     = '0;
      resp_ready    = '0;
      req_a         = '0;
      req_b         = '0;
      req_op[0]     = MUL_NONE;
      req_op[1]     = MUL_NONE;
      mul_in_ready  = 1'b0;
      mul_out_valid = 1'b0;
      mul_out_data  = '0;

      // Reset: nothing accepted even with requests pending
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mul_in_valid", 32'(mul_in_valid), 32'd0);
      chk("rst_mul_out_ready", 32'(mul_out_ready), 32'd0);
      chk("rst_mul_op", 32'(mul_op), 32'(MUL_NONE));
      tick();
      req_valid = '0;
      rst       = 1'b1;
      tick();

      single_job("mul", 0, 32'd3, 32'hFFFF_FFFE, MUL, 32'hFFFF_FFFA);
      single_job("mulhu", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU, 32'hFFFF_FFFE);
      single_job("mulhsu", 1, 32'hFFFF_FFFF, 32'd2, MULHSU, 32'hFFFF_FFFF);

      // Both continuously valid from rr_ptr=0: grants alternate 0,1,0,1
      req_a[0]  = 32'd6;
      req_b[0]  = 32'd7;
      req_op[0] = MUL;
      req_a[1]  = 32'h0001_0000;
      req_b[1]  = 32'h0001_0000;
      req_op[1] = MULHU;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         int r;
         r = i % 2;
         #1;
         chk("rr_req_ready", 32'(req_ready), (r == 0) ? 32'd1 : 32'd2);
         tick();
         if (r == 0) accept("rr0", 32'd6, 32'd7, MUL);
         else        accept("rr1", 32'h0001_0000, 32'h0001_0000, MULHU);
         complete("rr", 2);
         take_resp("rr", r, (r == 0) ? 32'h0000_002A : 32'h0000_0001);
      end
      req_valid = '0;

      // Owner backpressure holds the response and blocks the next issue
      req_a[0]  = 32'd9;
      req_b[0]  = 32'd9;
      req_op[0] = MUL;
      req_a[1]  = 32'd2;
      req_b[1]  = 32'd3;
      req_op[1] = MUL;
      req_valid = 2'b11;
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b10;
      accept("bp", 32'd9, 32'd9, MUL);
      complete("bp", 2);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_valid", 32'(resp_valid), 32'd1);
         chk("bp_hold_data", resp_data, 32'h0000_0051);
         chk("bp_no_issue", 32'(mul_in_valid), 32'd0);
         chk("bp_no_grant", 32'(req_ready), 32'd0);
         tick();
      end
      take_resp("bp", 0, 32'h0000_0051);
      #1;
      chk("bp1_req_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = '0;
      accept("bp1", 32'd2, 32'd3, MUL);
      complete("bp1", 1);
      take_resp("bp1", 1, 32'h0000_0006);

      // Flush before the multiplier takes the job: back to idle, nothing to drain
      req_a[1]  = 32'd8;
      req_b[1]  = 32'd8;
      req_op[1] = MUL;
      req_valid = 2'b10;
      #1;
      chk("fi_req_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = '0;
      chk("fi_in_valid", 32'(mul_in_valid), 32'd1);
      req_flush = 2'b10;
      tick();
      req_flush = '0;
      chk("fi_in_valid_drop", 32'(mul_in_valid), 32'd0);
      chk("fi_out_ready", 32'(mul_out_ready), 32'd0);

      // Flush of the owner while waiting: result drained, then requester 1 served
      req_a[0]  = 32'd4;
      req_b[0]  = 32'd4;
      req_op[0] = MUL;
      req_a[1]  = 32'd5;
      req_b[1]  = 32'd7;
      req_op[1] = MUL;
      req_valid = 2'b11;
      #1;
      chk("fw_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b10;
      accept("fw", 32'd4, 32'd4, MUL);
      tick();
      tick();
      req_flush = 2'b01;
      tick();
      req_flush = '0;
      chk("fw_drain_out_ready", 32'(mul_out_ready), 32'd1);
      chk("fw_drain_resp", 32'(resp_valid), 32'd0);
      chk("fw_drain_no_grant", 32'(req_ready), 32'd0);
      mul_out_valid = 1'b1;
      mul_out_data  = 32'h0000_0010;
      tick();
      mul_out_valid = 1'b0;
      mul_out_data  = '0;
      chk("fw_no_resp", 32'(resp_valid), 32'd0);
      #1;
      chk("fw1_req_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = '0;
      accept("fw1", 32'd5, 32'd7, MUL);
      complete("fw1", 2);
      take_resp("fw1", 1, 32'h0000_0023);

      // Asynchronous reset in the middle of a job
      req_a[1]  = 32'd7;
      req_b[1]  = 32'd7;
      req_op[1] = MUL;
      req_valid = 2'b10;
      #1;
      tick();
      req_valid = '0;
      accept("rw", 32'd7, 32'd7, MUL);
      chk("rw_out_ready", 32'(mul_out_ready), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rw_req_ready", 32'(req_ready), 32'd0);
      chk("rw_resp_valid", 32'(resp_valid), 32'd0);
      chk("rw_in_valid", 32'(mul_in_valid), 32'd0);
      chk("rw_out_ready_low", 32'(mul_out_ready), 32'd0);
      chk("rw_mul_a", mul_a, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      single_job("post_rst", 0, 32'd2, 32'd2, MUL, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
